// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and default widths for the FIFO pop-side blocks
package fifo_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } burst_state_t;

endpackage

// File: rtl/stream_reg.sv
// rtl/stream_reg.sv - single-entry valid/ready pipeline register with load enable and last sideband
module stream_reg
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // A load wins over a handshake so a pop and a drain can share one cycle.
  always_ff @(posedge clk) begin
    if (rest) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains an N-word burst from a show-ahead FIFO onto a valid/ready stream
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [WIDTH-1:0]     fifo_read_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  burst_state_t         state;
  logic [LEN_WIDTH-1:0] remain;
  logic                 pop;
  logic                 final_pop;
  logic                 handshake;

  // Pops are suppressed while reset is held so a reset cycle never consumes a FIFO word.
  assign pop       = !rest && (state == BURST) && (remain != '0) && !fifo_empty
                     && (!out_valid || out_ready);
  assign final_pop = pop && (remain == LEN_WIDTH'(1));
  assign handshake = out_valid && out_ready;
  assign fifo_read = pop;

  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= IDLE;
      remain    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            remain <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= BURST;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        BURST: begin
          if (pop) begin
            remain <= remain - LEN_WIDTH'(1);
          end
          if (final_pop) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (handshake && out_last) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  stream_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rest     (rest),
    .load     (pop),
    .load_data(fifo_read_data),
    .load_last(final_pop),
    .ready    (out_ready),
    .valid    (out_valid),
    .data     (out_data),
    .last     (out_last)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rest;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic        fifo_empty;
  logic        fifo_read;
  logic [31:0] fifo_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk           (clk),
    .rest          (rest),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_read_data(fifo_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  // Show-ahead FIFO model
  logic [31:0] mem [0:255];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int pop_cnt = 0;
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_read_data = mem[rd_ptr[7:0]];
  always @(posedge clk) begin
    if (fifo_read) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] held_data;
  logic [31:0] exp_w;
  logic        hold_pending = 1'b0;
  logic        gap_valid, gap_busy;
  int checks = 0, errors = 0;
  int last_cnt, last_idx, dcount, done_at, viol;

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic step();
    if (hold_pending) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data) begin
        errors++;
        $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h", out_valid, out_data, held_data);
      end
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (out_last) begin
        last_cnt++;
        last_idx = got_q.size() - 1;
      end
    end
    if (fifo_read && (fifo_empty || !busy)) viol++;
    hold_pending = out_valid && !out_ready && !rest;
    held_data    = out_data;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_burst(input int len, input int mode, input int late_at, input int late_n);
    got_q.delete();
    last_cnt = 0; last_idx = -1; dcount = 0; done_at = -1; viol = 0;
    hold_pending = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    for (int n = 0; n < 300; n++) begin
      if (n == late_at) begin
        gap_valid = out_valid;
        gap_busy  = busy;
        for (int k = 0; k < late_n; k++) push_word($urandom);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (n > 0 && done) begin
        dcount++;
        if (done_at < 0) done_at = n;
      end
      step();
      if (n == 0) cmd_valid = 1'b0;
      if (done_at >= 0 && n > done_at) break;
    end
  endtask

  task automatic test_reset();
    rest = 1'b1; cmd_valid = 1'b0; cmd_len = '0; out_ready = 1'b0;
    step(); step();
    rest = 1'b0;
    step();
    for (int i = 0; i < 4; i++) push_word($urandom);
    rest = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || fifo_read !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%0b rd=%0b ov=%0b busy=%0b done=%0b required 1,0,0,0,0",
               cmd_ready, fifo_read, out_valid, busy, done);
    end
    checks++;
    if (out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%h last=%0b required 0,0", out_data, out_last);
    end
    checks++;
    if (pop_cnt !== 0 || (wr_ptr - rd_ptr) !== 4) begin
      errors++;
      $display("FAIL reset_no_pop: pops=%0d level=%0d required 0,4", pop_cnt, wr_ptr - rd_ptr);
    end
    rest = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || fifo_read !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rdy=%0b rd=%0b busy=%0b required 1,0,0", cmd_ready, fifo_read, busy);
    end
  endtask

  task automatic test_basic();
    int p0 = pop_cnt;
    run_burst(4, 0, -1, 0);
    checks++;
    if (got_q.size() !== 4) begin
      errors++;
      $display("FAIL basic_count: got %0d words required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp_w = exp_q.pop_front();
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_w) begin
          errors++;
          $display("FAIL basic_word%0d: got %h required %h", i, got_q[i], exp_w);
        end
      end
    end
    checks++;
    if (last_cnt !== 1 || last_idx !== 3) begin
      errors++;
      $display("FAIL basic_last: count=%0d idx=%0d required 1,3", last_cnt, last_idx);
    end
    checks++;
    if (dcount !== 1 || done_at !== 6) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d at=%0d required 1 at 6", dcount, done_at);
    end
    checks++;
    if (pop_cnt - p0 !== 4 || fifo_empty !== 1'b1 || viol !== 0) begin
      errors++;
      $display("FAIL basic_pops: pops=%0d empty=%0b viol=%0d required 4,1,0", pop_cnt - p0, fifo_empty, viol);
    end
  endtask

  task automatic test_backpressure();
    int p0 = pop_cnt;
    for (int i = 0; i < 3; i++) push_word($urandom);
    run_burst(3, 1, -1, 0);
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("FAIL bp_count: got %0d words required 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      exp_w = exp_q.pop_front();
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_w) begin
          errors++;
          $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_w);
        end
      end
    end
    checks++;
    if (pop_cnt - p0 !== 3 || dcount !== 1 || viol !== 0) begin
      errors++;
      $display("FAIL bp_pops: pops=%0d done=%0d viol=%0d required 3,1,0", pop_cnt - p0, dcount, viol);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 2; i++) push_word($urandom);
    run_burst(5, 0, 10, 3);
    checks++;
    if (gap_valid !== 1'b0 || gap_busy !== 1'b1) begin
      errors++;
      $display("FAIL uf_gap: out_valid=%0b busy=%0b required 0,1", gap_valid, gap_busy);
    end
    checks++;
    if (got_q.size() !== 5 || dcount !== 1 || viol !== 0) begin
      errors++;
      $display("FAIL uf_count: words=%0d done=%0d viol=%0d required 5,1,0", got_q.size(), dcount, viol);
    end
    for (int i = 0; i < 5; i++) begin
      exp_w = exp_q.pop_front();
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_w) begin
          errors++;
          $display("FAIL uf_word%0d: got %h required %h", i, got_q[i], exp_w);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pop_cnt;
    for (int i = 0; i < 2; i++) push_word($urandom);
    cmd_valid = 1'b1; cmd_len = 8'd0; out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || pop_cnt !== p0) begin
      errors++;
      $display("FAIL zero_len: done=%0b rdy=%0b pops=%0d required 1,1,0", done, cmd_ready, pop_cnt - p0);
    end
    run_burst(2, 0, -1, 0);
    checks++;
    if (dcount !== 1 || done_at !== 4 || pop_cnt - p0 !== 2) begin
      errors++;
      $display("FAIL b2b_timing: done=%0d at=%0d pops=%0d required 1 at 4, 2", dcount, done_at, pop_cnt - p0);
    end
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d words required 2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      exp_w = exp_q.pop_front();
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_w) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_w);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int len = $urandom_range(1, 12);
      int p0  = pop_cnt;
      for (int i = 0; i < len; i++) push_word($urandom);
      run_burst(len, 2, -1, 0);
      checks++;
      if (got_q.size() !== len || dcount !== 1 || pop_cnt - p0 !== len || last_idx !== len - 1) begin
        errors++;
        $display("FAIL rand%0d_count: words=%0d done=%0d pops=%0d last=%0d required len %0d, 1 done",
                 it, got_q.size(), dcount, pop_cnt - p0, last_idx, len);
      end
      for (int i = 0; i < len; i++) begin
        exp_w = exp_q.pop_front();
        if (i < got_q.size()) begin
          checks++;
          if (got_q[i] !== exp_w) begin
            errors++;
            $display("FAIL rand%0d_word%0d: got %h required %h", it, i, got_q[i], exp_w);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int p0 = pop_cnt;
    int dseen = 0;
    for (int i = 0; i < 8; i++) push_word($urandom);
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_len = 8'd8;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pop_cnt - p0 >= 3) break;
      step();
    end
    rest = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_read: fifo_read=%0b required 0", fifo_read);
    end
    step();
    rest = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: ov=%0b busy=%0b done=%0b rdy=%0b required 0,0,0,1",
               out_valid, busy, done, cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      if (done) dseen++;
      step();
    end
    checks++;
    if (dseen !== 0 || pop_cnt - p0 !== 3 || (wr_ptr - rd_ptr) !== 5) begin
      errors++;
      $display("FAIL rst_mid_fifo: done=%0d pops=%0d level=%0d required 0,3,5", dseen, pop_cnt - p0, wr_ptr - rd_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
